nx_stream_arbiter: RTL and testbench
====================================

// Module: nx_stream_arbiter
// PURPOSE
// - Per-node inbound router of the nexus mesh. Merges the N/E/S/W message streams with round-robin fairness.
// - Messages addressed to this node go to the internal stream; all others go to the bypass stream with an egress direction.
// - Both outputs are registered valid/ready streams: 1-cycle latency, one message accepted per cycle.
// PARAMETERS
// - ADDR_ROW_WIDTH  4  width of the row address (node_row_i, message row field)
// - ADDR_COL_WIDTH  4  width of the column address (node_col_i, message column field)
// PORTS
// - clk_i             in   1    single clock, rising edge
// - rst_i             in   1    reset, asynchronous, active-low
// - node_row_i        in   ADDR_ROW_WIDTH  this node's row (quasi-static)
// - node_col_i        in   ADDR_COL_WIDTH  this node's column (quasi-static)
// - {north,east,south,west}_data_i   in   nx_message_t  inbound message
// - {north,east,south,west}_valid_i  in   1    inbound valid
// - {north,east,south,west}_ready_o  out  1    inbound accept (transfer = valid & ready)
// - internal_data_o/valid_o  out  nx_message_t/1  stream to this node
// - internal_ready_i  in   1    internal consumer ready
// - bypass_data_o/dir_o/valid_o  out  nx_message_t/nx_direction_t/1  forwarded message + egress side
// - bypass_ready_i    in   1    bypass consumer ready
// BEHAVIOUR
// - Routing on the message row/col fields:
//   - row==node_row_i && col==node_col_i: internal.
//   - else bypass, rows first: row<node -> NORTH, row>node -> SOUTH; else col>node -> EAST, col<node -> WEST.
//   - Row increases southward, column increases eastward.
// - Output slots: each output has one register. A slot can accept when !valid_o | ready_i (pass-through on drain).
// - Eligible input: valid, and its decoded destination slot can accept. Blocked inputs never stall eligible ones.
// - Arbitration: one grant per cycle among eligible inputs. Priority order is N,E,S,W rotated to start after the last granted input.
// - Pointer update: the pointer moves to the granted input only on a grant; no grant leaves it unchanged.
// - Ready: X_ready_o = grant[X], a combinational function of the valids and the slot states.
//   - Held low while rst_i is low.
//   - At most one ready is high per cycle.
// - Transfer effects: the granted message is loaded into its slot and valid set the next edge.
//   - The slot's valid clears when consumed with no new load.
//   - Data/dir hold while valid & !ready.
// - Bypass direction is computed at load and registered alongside the data.
// - Reset (async, rst_i low):
//   - internal_valid_o=0, bypass_valid_o=0, data outputs=0, bypass_dir_o=NORTH.
//   - Arbiter pointer = WEST, so NORTH has first priority.
//   - Mid-operation reset drops held messages.
// - Simultaneous: a slot drained and reloaded in the same cycle gives back-to-back throughput. Both outputs may be valid at once.
// STRUCTURE
// - Shared package nx_common_pkg:
//   - nx_message_t: packed struct {row[3:0], col[3:0], command[1:0], payload[21:0]}, 32 bits.
//   - nx_direction_t: enum 2b {NORTH=0, EAST=1, SOUTH=2, WEST=3}.
// - Sub-module nx_rr_arbiter #(N=4): req[N], advance -> one-hot grant; holds the rotating pointer.
// - Top level: address decode per input, eligibility mask, two output slot registers.
// TESTING
// - Reset low with all inputs valid -> all ready_o=0, both valid_o=0. After release (node 2,2), NORTH msg to (2,2)
//   -> north_ready_o=1, internal_valid_o=1 next cycle with identical data.
// - Node (2,2), east msg to (0,2) and west msg to (2,3), both outputs ready -> EAST granted, bypass dir=NORTH.
//   Next cycle WEST granted, dir=EAST.
// - All four inputs valid to bypass (5,5), bypass_ready_i=1 -> grants cycle N,E,S,W,N. One transfer per cycle, no starvation.
// - internal_ready_i=0 with internal slot full, north->self, south->bypass -> south granted, north_ready_o stays 0.
//   Raise internal_ready_i -> north granted in that same cycle.
// - bypass_ready_i=0 for 3 cycles with bypass valid -> bypass_data_o/dir_o/valid_o stable, no further bypass grants.
// - Assert rst_i low mid-stream with both slots valid -> both valid_o drop immediately (async).
//   After release, first grant goes to NORTH.

Source files
------------

// File: rtl/nx_common_pkg.sv
// Shared nexus mesh types: message layout, egress direction encoding and the
// address-decode helper used by every per-node router.
package nx_common_pkg;

    localparam int NX_ROW_WIDTH = 4;
    localparam int NX_COL_WIDTH = 4;
    localparam int NX_PORTS     = 4;

    typedef struct packed {
        logic [NX_ROW_WIDTH-1:0] row;
        logic [NX_COL_WIDTH-1:0] col;
        logic [1:0]              command;
        logic [21:0]             payload;
    } nx_message_t;

    // Encoding doubles as the inbound port index (north=0 ... west=3).
    typedef enum logic [1:0] {
        NORTH = 2'd0,
        EAST  = 2'd1,
        SOUTH = 2'd2,
        WEST  = 2'd3
    } nx_direction_t;

    typedef struct packed {
        logic          local_hit;
        nx_direction_t dir;
    } nx_route_t;

    // Dimension-ordered routing: resolve the row first, then the column.
    // Rows grow southward, columns grow eastward.
    function automatic nx_route_t nx_route(
        input nx_message_t             msg,
        input logic [NX_ROW_WIDTH-1:0] node_row,
        input logic [NX_COL_WIDTH-1:0] node_col
    );
        nx_route_t route;
        route.local_hit = 1'b0;
        route.dir       = NORTH;
        if (msg.row < node_row) begin
            route.dir = NORTH;
        end else if (msg.row > node_row) begin
            route.dir = SOUTH;
        end else if (msg.col > node_col) begin
            route.dir = EAST;
        end else if (msg.col < node_col) begin
            route.dir = WEST;
        end else begin
            route.local_hit = 1'b1;
        end
        return route;
    endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant among requesters, with the search
// starting just after the most recently granted index.
module nx_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] PTR_INIT = PW'(N - 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic          found;

    // NOTE: every combinational output gets a default before the loop so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        winner = ptr;
        found  = 1'b0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                winner     = PW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    // The pointer only moves when somebody actually won.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr <= PTR_INIT;
        end else if (advance && found) begin
            ptr <= winner;
        end
    end

endmodule

// File: rtl/nx_stream_arbiter.sv
// Per-node inbound router: merges N/E/S/W streams round-robin and splits them
// into a registered internal stream and a registered bypass stream.
module nx_stream_arbiter
    import nx_common_pkg::*;
#(
    parameter int ADDR_ROW_WIDTH = NX_ROW_WIDTH,
    parameter int ADDR_COL_WIDTH = NX_COL_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0] node_col_i,

    input  nx_message_t               north_data_i,
    input  logic                      north_valid_i,
    output logic                      north_ready_o,
    input  nx_message_t               east_data_i,
    input  logic                      east_valid_i,
    output logic                      east_ready_o,
    input  nx_message_t               south_data_i,
    input  logic                      south_valid_i,
    output logic                      south_ready_o,
    input  nx_message_t               west_data_i,
    input  logic                      west_valid_i,
    output logic                      west_ready_o,

    output nx_message_t               internal_data_o,
    output logic                      internal_valid_o,
    input  logic                      internal_ready_i,

    output nx_message_t               bypass_data_o,
    output nx_direction_t             bypass_dir_o,
    output logic                      bypass_valid_o,
    input  logic                      bypass_ready_i
);

    nx_message_t           in_data  [NX_PORTS];
    nx_route_t             in_route [NX_PORTS];
    logic [NX_PORTS-1:0]   in_valid;
    logic [NX_PORTS-1:0]   eligible;
    logic [NX_PORTS-1:0]   grant;

    logic                  internal_open;
    logic                  bypass_open;

    nx_message_t           sel_data;
    nx_direction_t         sel_dir;
    logic                  sel_local;
    logic                  load_internal;
    logic                  load_bypass;

    assign in_data[0] = north_data_i;
    assign in_data[1] = east_data_i;
    assign in_data[2] = south_data_i;
    assign in_data[3] = west_data_i;
    assign in_valid   = {west_valid_i, south_valid_i, east_valid_i, north_valid_i};

    // A slot can take a new message when empty or being drained this cycle.
    assign internal_open = !internal_valid_o || internal_ready_i;
    assign bypass_open   = !bypass_valid_o || bypass_ready_i;

    always_comb begin
        for (int i = 0; i < NX_PORTS; i++) begin
            in_route[i] = nx_route(in_data[i], node_row_i, node_col_i);
        end
    end

    // Inputs whose destination slot is full drop out of arbitration so they
    // never block an input headed for the other slot. Gating with the reset
    // keeps every ready low while reset is asserted.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NX_PORTS; i++) begin
            eligible[i] = rst_i && in_valid[i] &&
                          (in_route[i].local_hit ? internal_open : bypass_open);
        end
    end

    nx_rr_arbiter #(
        .N       (NX_PORTS)
    ) u_arbiter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (eligible),
        .advance (1'b1),
        .grant   (grant)
    );

    assign north_ready_o = grant[0];
    assign east_ready_o  = grant[1];
    assign south_ready_o = grant[2];
    assign west_ready_o  = grant[3];

    always_comb begin
        sel_data  = '0;
        sel_dir   = NORTH;
        sel_local = 1'b0;
        for (int i = 0; i < NX_PORTS; i++) begin
            if (grant[i]) begin
                sel_data  = in_data[i];
                sel_dir   = in_route[i].dir;
                sel_local = in_route[i].local_hit;
            end
        end
    end

    assign load_internal = |grant && sel_local;
    assign load_bypass   = |grant && !sel_local;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            internal_valid_o <= 1'b0;
            internal_data_o  <= '0;
        end else if (load_internal) begin
            internal_valid_o <= 1'b1;
            internal_data_o  <= sel_data;
        end else if (internal_ready_i) begin
            internal_valid_o <= 1'b0;
        end
    end

    // The egress side is decided once at load time and travels with the data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bypass_valid_o <= 1'b0;
            bypass_data_o  <= '0;
            bypass_dir_o   <= NORTH;
        end else if (load_bypass) begin
            bypass_valid_o <= 1'b1;
            bypass_data_o  <= sel_data;
            bypass_dir_o   <= sel_dir;
        end else if (bypass_ready_i) begin
            bypass_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Self-checking bench for nx_stream_arbiter: directed vector table, reset
// sequences, then randomized traffic against a queue-free behavioural model.
module tb_nx_stream_arbiter;
    import nx_common_pkg::*;

    typedef nx_message_t [3:0] msg4_t;

    typedef struct {
        logic [3:0]    vld;
        msg4_t         msg;
        logic          ir;
        logic          br;
        logic [3:0]    exp_rdy;
        logic          exp_iv;
        nx_message_t   exp_id;
        logic          exp_bv;
        nx_message_t   exp_bd;
        nx_direction_t exp_bdir;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [3:0]    node_row_i;
    logic [3:0]    node_col_i;
    nx_message_t   north_data_i, east_data_i, south_data_i, west_data_i;
    logic          north_valid_i, east_valid_i, south_valid_i, west_valid_i;
    logic          north_ready_o, east_ready_o, south_ready_o, west_ready_o;
    nx_message_t   internal_data_o;
    logic          internal_valid_o;
    logic          internal_ready_i;
    nx_message_t   bypass_data_o;
    nx_direction_t bypass_dir_o;
    logic          bypass_valid_o;
    logic          bypass_ready_i;
    logic [3:0]    rdy;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[16];

    always #5 clk_i = ~clk_i;

    assign rdy = {west_ready_o, south_ready_o, east_ready_o, north_ready_o};

    nx_stream_arbiter dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .node_row_i       (node_row_i),
        .node_col_i       (node_col_i),
        .north_data_i     (north_data_i),
        .north_valid_i    (north_valid_i),
        .north_ready_o    (north_ready_o),
        .east_data_i      (east_data_i),
        .east_valid_i     (east_valid_i),
        .east_ready_o     (east_ready_o),
        .south_data_i     (south_data_i),
        .south_valid_i    (south_valid_i),
        .south_ready_o    (south_ready_o),
        .west_data_i      (west_data_i),
        .west_valid_i     (west_valid_i),
        .west_ready_o     (west_ready_o),
        .internal_data_o  (internal_data_o),
        .internal_valid_o (internal_valid_o),
        .internal_ready_i (internal_ready_i),
        .bypass_data_o    (bypass_data_o),
        .bypass_dir_o     (bypass_dir_o),
        .bypass_valid_o   (bypass_valid_o),
        .bypass_ready_i   (bypass_ready_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic nx_message_t mk(input int r, input int c, input int cmd, input int pl);
        nx_message_t m;
        m.row     = 4'(r);
        m.col     = 4'(c);
        m.command = 2'(cmd);
        m.payload = 22'(pl);
        return m;
    endfunction

    function automatic msg4_t m4(input nx_message_t n, input nx_message_t e,
                                 input nx_message_t s, input nx_message_t w);
        msg4_t r;
        r[0] = n;
        r[1] = e;
        r[2] = s;
        r[3] = w;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [3:0] vld, input msg4_t msg, input logic ir,
                                 input logic br, input logic [3:0] rdy_e, input logic iv,
                                 input nx_message_t id, input logic bv, input nx_message_t bd,
                                 input nx_direction_t bdir);
        vec_t v;
        v.vld      = vld;
        v.msg      = msg;
        v.ir       = ir;
        v.br       = br;
        v.exp_rdy  = rdy_e;
        v.exp_iv   = iv;
        v.exp_id   = id;
        v.exp_bv   = bv;
        v.exp_bd   = bd;
        v.exp_bdir = bdir;
        return v;
    endfunction

    task automatic drive(input logic [3:0] vld, input msg4_t msg, input logic ir, input logic br);
        north_valid_i    = vld[0];
        east_valid_i     = vld[1];
        south_valid_i    = vld[2];
        west_valid_i     = vld[3];
        north_data_i     = msg[0];
        east_data_i      = msg[1];
        south_data_i     = msg[2];
        west_data_i      = msg[3];
        internal_ready_i = ir;
        bypass_ready_i   = br;
    endtask

    // Inputs change on the falling edge; readies are sampled mid-cycle and
    // registered outputs 1 time unit after the rising edge.
    task automatic apply(input vec_t v, input int n);
        @(negedge clk_i);
        drive(v.vld, v.msg, v.ir, v.br);
        #1;
        check($sformatf("vec%0d ready", n), 64'(rdy), 64'(v.exp_rdy));
        @(posedge clk_i);
        #1;
        check($sformatf("vec%0d internal_valid", n), 64'(internal_valid_o), 64'(v.exp_iv));
        if (v.exp_iv) check($sformatf("vec%0d internal_data", n), 64'(internal_data_o), 64'(v.exp_id));
        check($sformatf("vec%0d bypass_valid", n), 64'(bypass_valid_o), 64'(v.exp_bv));
        if (v.exp_bv) begin
            check($sformatf("vec%0d bypass_data", n), 64'(bypass_data_o), 64'(v.exp_bd));
            check($sformatf("vec%0d bypass_dir", n), 64'(bypass_dir_o), 64'(v.exp_bdir));
        end
    endtask

    // Reference routing: 4 means "this node", 0..3 is the N/E/S/W egress side.
    function automatic int tb_dest(input nx_message_t m);
        int r, c, nr, nc;
        r  = int'(m.row);
        c  = int'(m.col);
        nr = int'(node_row_i);
        nc = int'(node_col_i);
        if (r < nr) return 0;
        if (r > nr) return 2;
        if (c > nc) return 1;
        if (c < nc) return 3;
        return 4;
    endfunction

    nx_message_t ma, mb, mc, ma2, me, mf, mg, z;
    nx_message_t d[4];

    initial begin
        z   = '0;
        ma  = mk(2, 2, 1, 'h11111);
        mb  = mk(0, 2, 2, 'h22222);
        mc  = mk(2, 3, 3, 'h33333);
        ma2 = mk(2, 2, 0, 'h2A2A2);
        me  = mk(5, 5, 1, 'h3E3E3);
        mf  = mk(5, 5, 2, 'h0F0F0);
        mg  = mk(5, 5, 3, 'h06060);
        for (int i = 0; i < 4; i++) d[i] = mk(5, 5, 0, 'h100 + i);

        vecs[0]  = mkv(4'b0001, m4(ma, z, z, z), 1, 1, 4'b0001, 1, ma, 0, z, NORTH);
        vecs[1]  = mkv(4'b1010, m4(z, mb, z, mc), 1, 1, 4'b0010, 0, z, 1, mb, NORTH);
        vecs[2]  = mkv(4'b1000, m4(z, z, z, mc), 1, 1, 4'b1000, 0, z, 1, mc, EAST);
        vecs[3]  = mkv(4'b1111, m4(d[0], d[1], d[2], d[3]), 1, 1, 4'b0001, 0, z, 1, d[0], SOUTH);
        vecs[4]  = mkv(4'b1111, m4(d[0], d[1], d[2], d[3]), 1, 1, 4'b0010, 0, z, 1, d[1], SOUTH);
        vecs[5]  = mkv(4'b1111, m4(d[0], d[1], d[2], d[3]), 1, 1, 4'b0100, 0, z, 1, d[2], SOUTH);
        vecs[6]  = mkv(4'b1111, m4(d[0], d[1], d[2], d[3]), 1, 1, 4'b1000, 0, z, 1, d[3], SOUTH);
        vecs[7]  = mkv(4'b1111, m4(d[0], d[1], d[2], d[3]), 1, 1, 4'b0001, 0, z, 1, d[0], SOUTH);
        vecs[8]  = mkv(4'b0001, m4(ma, z, z, z), 1, 1, 4'b0001, 1, ma, 0, z, NORTH);
        vecs[9]  = mkv(4'b0101, m4(ma2, z, me, z), 0, 1, 4'b0100, 1, ma, 1, me, SOUTH);
        vecs[10] = mkv(4'b0001, m4(ma2, z, z, z), 1, 1, 4'b0001, 1, ma2, 0, z, NORTH);
        vecs[11] = mkv(4'b0010, m4(z, mf, z, z), 1, 1, 4'b0010, 0, z, 1, mf, SOUTH);
        vecs[12] = mkv(4'b0010, m4(z, mg, z, z), 1, 0, 4'b0000, 0, z, 1, mf, SOUTH);
        vecs[13] = mkv(4'b0011, m4(ma, mg, z, z), 1, 0, 4'b0001, 1, ma, 1, mf, SOUTH);
        vecs[14] = mkv(4'b0010, m4(z, mg, z, z), 1, 0, 4'b0000, 0, z, 1, mf, SOUTH);
        vecs[15] = mkv(4'b0010, m4(z, mg, z, z), 1, 1, 4'b0010, 0, z, 1, mg, SOUTH);

        // Reset held with every input valid: nothing may be accepted.
        node_row_i = 4'd2;
        node_col_i = 4'd2;
        rst_i      = 1'b0;
        drive(4'b1111, m4(d[0], d[1], d[2], d[3]), 1, 1);
        #1;
        check("reset ready", 64'(rdy), 64'(0));
        check("reset internal_valid", 64'(internal_valid_o), 64'(0));
        check("reset bypass_valid", 64'(bypass_valid_o), 64'(0));
        check("reset internal_data", 64'(internal_data_o), 64'(0));
        check("reset bypass_data", 64'(bypass_data_o), 64'(0));
        check("reset bypass_dir", 64'(bypass_dir_o), 64'(NORTH));
        repeat (2) @(posedge clk_i);
        #1;
        check("reset held ready", 64'(rdy), 64'(0));
        check("reset held valids", 64'({internal_valid_o, bypass_valid_o}), 64'(0));
        @(negedge clk_i);
        drive(4'b0000, m4(z, z, z, z), 1, 1);
        rst_i = 1'b1;

        for (int i = 0; i < 16; i++) apply(vecs[i], i);

        // Fill both slots, then reset asynchronously mid-cycle.
        @(negedge clk_i);
        drive(4'b0011, m4(ma, mf, z, z), 0, 0);
        #1;
        check("prerst ready", 64'(rdy), 64'(4'b0001));
        @(posedge clk_i);
        #1;
        check("prerst both valid", 64'({internal_valid_o, bypass_valid_o}), 64'(2'b11));
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst valids async", 64'({internal_valid_o, bypass_valid_o}), 64'(0));
        check("midrst ready", 64'(rdy), 64'(0));
        @(negedge clk_i);
        drive(4'b1111, m4(d[0], d[1], d[2], d[3]), 1, 1);
        rst_i = 1'b1;
        #1;
        check("postrst first grant", 64'(rdy), 64'(4'b0001));
        @(posedge clk_i);
        #1;
        check("postrst bypass_valid", 64'(bypass_valid_o), 64'(1));
        check("postrst bypass_data", 64'(bypass_data_o), 64'(d[0]));

        // Randomized traffic against the behavioural model.
        begin
            int          last;
            logic        m_iv, m_bv;
            nx_message_t m_id, m_bd;
            int          m_bdir;
            logic [3:0]  v;
            msg4_t       msg;
            logic        ir, br;
            int          win;
            logic [3:0]  exp_rdy;

            @(negedge clk_i);
            drive(4'b0000, m4(z, z, z, z), 1, 1);
            rst_i = 1'b0;
            @(negedge clk_i);
            rst_i  = 1'b1;
            last   = 3;
            m_iv   = 1'b0;
            m_bv   = 1'b0;
            m_id   = '0;
            m_bd   = '0;
            m_bdir = 0;

            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk_i);
                v = 4'($urandom_range(0, 15));
                for (int p = 0; p < 4; p++)
                    msg[p] = mk($urandom_range(1, 3), $urandom_range(1, 3),
                                $urandom_range(0, 3), $urandom_range(0, 'h3FFFFF));
                ir = ($urandom_range(0, 3) != 0);
                br = ($urandom_range(0, 3) != 0);
                drive(v, msg, ir, br);
                #1;
                win = -1;
                for (int k = 1; k <= 4; k++) begin
                    int p;
                    p = (last + k) % 4;
                    if (win < 0 && v[p]) begin
                        if (tb_dest(msg[p]) == 4) begin
                            if (!m_iv || ir) win = p;
                        end else begin
                            if (!m_bv || br) win = p;
                        end
                    end
                end
                exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0000;
                check($sformatf("rnd%0d ready", cyc), 64'(rdy), 64'(exp_rdy));
                check($sformatf("rnd%0d internal_valid", cyc), 64'(internal_valid_o), 64'(m_iv));
                if (m_iv) check($sformatf("rnd%0d internal_data", cyc), 64'(internal_data_o), 64'(m_id));
                check($sformatf("rnd%0d bypass_valid", cyc), 64'(bypass_valid_o), 64'(m_bv));
                if (m_bv) begin
                    check($sformatf("rnd%0d bypass_data", cyc), 64'(bypass_data_o), 64'(m_bd));
                    check($sformatf("rnd%0d bypass_dir", cyc), 64'(bypass_dir_o), 64'(m_bdir));
                end
                @(posedge clk_i);
                if (m_iv && ir) m_iv = 1'b0;
                if (m_bv && br) m_bv = 1'b0;
                if (win >= 0) begin
                    last = win;
                    if (tb_dest(msg[win]) == 4) begin
                        m_iv = 1'b1;
                        m_id = msg[win];
                    end else begin
                        m_bv   = 1'b1;
                        m_bd   = msg[win];
                        m_bdir = tb_dest(msg[win]);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
